vco_sample_ctrl: RTL

Sequencer and decimator for the ring-VCO quantizer. It drives the VCO's active-low enable and runs a settle window. It then samples the VCO phase bus every clk, forms modulo-2^PHASE_WIDTH phase increments and integrates them over a programmable oversampling window. One decimated sample per window goes out on a valid/ready interface toward the digital filter/wishbone readout.

---
 rtl/vco_sample_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/vco_sample_ctrl.sv
// Ring-VCO quantizer sequencer/decimator: enables the VCO, waits a settle window, then
// integrates phase increments over osr cycles. Optional Gray-coded phase input: VCO_GRAY_DECODE_EN.
module vco_sample_ctrl #(
   parameter int PHASE_WIDTH   = 11,
   parameter int OSR_WIDTH     = 10,
   parameter int OUT_WIDTH     = 21,
   parameter int SETTLE_CYCLES = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   stop,
   input  logic [OSR_WIDTH-1:0]   osr,
   output logic                   vco_enb,
   input  logic [PHASE_WIDTH-1:0] vco_p,
   output logic [OUT_WIDTH-1:0]   out_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   busy,
   output logic                   overrun
);

   localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      PRIME  = 2'd2,
      ACCUM  = 2'd3
   } state_t;

   state_t                 state;
   logic [PHASE_WIDTH-1:0] ph_in;
   logic [PHASE_WIDTH-1:0] ph_q;
   logic [PHASE_WIDTH-1:0] prev;
   logic [PHASE_WIDTH-1:0] diff;
   logic [OUT_WIDTH-1:0]   acc;
   logic [OUT_WIDTH-1:0]   sum;
   logic [OSR_WIDTH:0]     cnt;
   logic [OSR_WIDTH:0]     osr_l;
   logic [OSR_WIDTH:0]     osr_last;
   logic [SW-1:0]          settle_cnt;
   logic                   window_end;

`ifdef VCO_GRAY_DECODE_EN
   // Each binary bit is the XOR of all Gray bits at or above it.
   genvar gi;
   generate
      for (gi = 0; gi < PHASE_WIDTH; gi++) begin : g_gray
         assign ph_in[gi] = ^vco_p[PHASE_WIDTH-1:gi];
      end
   endgenerate
`else
   assign ph_in = vco_p;
`endif

   // Modulo subtraction makes a wrap from all-ones to zero a small positive step.
   assign diff       = ph_q - prev;
   assign sum        = acc + {{(OUT_WIDTH-PHASE_WIDTH){1'b0}}, diff};
   assign osr_last   = osr_l - 1'b1;
   assign window_end = (cnt == osr_last);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         vco_enb    <= 1'b1;
         out_data   <= '0;
         out_valid  <= 1'b0;
         overrun    <= 1'b0;
         busy       <= 1'b0;
         acc        <= '0;
         cnt        <= '0;
         prev       <= '0;
         osr_l      <= '0;
         ph_q       <= '0;
         settle_cnt <= '0;
      end else begin
         ph_q <= ph_in;
         if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
         case (state)
            IDLE: begin
               vco_enb <= 1'b1;
               busy    <= 1'b0;
               if (start && !stop) begin
                  osr_l      <= (osr == '0) ? {1'b1, {OSR_WIDTH{1'b0}}} : {1'b0, osr};
                  acc        <= '0;
                  cnt        <= '0;
                  overrun    <= 1'b0;
                  settle_cnt <= '0;
                  vco_enb    <= 1'b0;
                  busy       <= 1'b1;
                  state      <= SETTLE;
               end
            end
            SETTLE: begin
               if (stop) begin
                  state   <= IDLE;
                  vco_enb <= 1'b1;
                  busy    <= 1'b0;
               end else if (settle_cnt == SETTLE_LAST) begin
                  state <= PRIME;
               end else begin
                  settle_cnt <= settle_cnt + 1'b1;
               end
            end
            PRIME: begin
               if (stop) begin
                  state   <= IDLE;
                  vco_enb <= 1'b1;
                  busy    <= 1'b0;
               end else begin
                  prev  <= ph_q;
                  state <= ACCUM;
               end
            end
            ACCUM: begin
               if (stop) begin
                  state   <= IDLE;
                  vco_enb <= 1'b1;
                  busy    <= 1'b0;
                  acc     <= '0;
                  cnt     <= '0;
               end else begin
                  prev <= ph_q;
                  if (window_end) begin
                     acc <= '0;
                     cnt <= '0;
                     // Single-entry output: a full, unaccepted register drops the new sample.
                     if (!out_valid || out_ready) begin
                        out_data  <= sum;
                        out_valid <= 1'b1;
                     end else begin
                        overrun <= 1'b1;
                     end
                  end else begin
                     acc <= sum;
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
